clz_restore: RTL and testbench

//  Multi-cycle denormalizer; the inverse of the leading-zero counter.

---
 rtl/clz_restore_if.sv | 26 ++
 rtl/clz_restore.sv | 127 ++++++++++++
 tb/tb_clz_restore.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/clz_restore_if.sv
// Handshake and data bundle for the clz_restore denormalizer.
// master: the requester (drives start/norm_in/shift_amt).
// slave:  the denormalizer (drives busy/done/data_out/err/sticky).
interface clz_restore_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start;
    logic [WIDTH-1:0] norm_in;
    logic [CNT_W-1:0] shift_amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic             err;
    logic             sticky;

    modport master (
        output start, norm_in, shift_amt,
        input  busy, done, data_out, err, sticky
    );

    modport slave (
        input  start, norm_in, shift_amt,
        output busy, done, data_out, err, sticky
    );
endinterface

// File: rtl/clz_restore.sv
// clz_restore: multi-cycle denormalizer, data_out = norm_in >> shift_amt.
// Shifts COARSE bits per cycle while enough count remains, then single bits.
// Optional feature macro: CLZ_RESTORE_STICKY_EN builds the sticky OR of all
// discarded bits; without it sticky is tied low.
module clz_restore #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 6,
    parameter int COARSE = 8
) (
    input  logic         clk,
    input  logic         rst,
    clz_restore_if.slave bus
);
    localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] COARSE_C = CNT_W'(COARSE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] rem_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic             use_coarse;
    logic [WIDTH-1:0] data_next;
    logic [CNT_W-1:0] rem_next;
    logic             over_range;
    logic [CNT_W-1:0] rem_load;
    logic             accept;

    // Next shift step and clamped load count for a new request.
    always_comb begin
        use_coarse = (rem_reg >= COARSE_C);
        data_next  = data_reg >> 1;
        rem_next   = rem_reg - CNT_W'(1);
        if (use_coarse) begin
            data_next = data_reg >> COARSE;
            rem_next  = rem_reg - COARSE_C;
        end
        over_range = (bus.shift_amt > WIDTH_C);
        rem_load   = over_range ? WIDTH_C : bus.shift_amt;
        accept     = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
    end

    // Control FSM with registered busy/done, plus the working data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            rem_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (accept) begin
                        data_reg <= bus.norm_in;
                        rem_reg  <= rem_load;
                        err_reg  <= over_range;
                        if (rem_load == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    data_reg <= data_next;
                    rem_reg  <= rem_next;
                    if (rem_next == '0) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLZ_RESTORE_STICKY_EN
    logic sticky_reg;
    logic lost_bits;

    // Bits falling off the LSB end during the current shift step.
    always_comb begin
        lost_bits = use_coarse ? (|data_reg[COARSE-1:0]) : data_reg[0];
    end

    // Sticky accumulates discarded bits; cleared on each accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (accept) begin
            sticky_reg <= 1'b0;
        end else if (state_reg == SHIFT) begin
            sticky_reg <= sticky_reg | lost_bits;
        end
    end

    assign bus.sticky = sticky_reg;
`else
    assign bus.sticky = 1'b0;
`endif

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.data_out = data_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_clz_restore.sv
// Directed testbench for clz_restore: vector table, handshake corner cases,
// asynchronous reset abort and a random round trip through a clz model.
module tb_clz_restore;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
`ifdef CLZ_RESTORE_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    clz_restore_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_if ();

    clz_restore #(.WIDTH(WIDTH), .CNT_W(CNT_W), .COARSE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [5:0]  amt;
        logic [31:0] d;
        bit          e;
        bit          s;
        int          lat;
        bit          bsy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clz32(input logic [31:0] v);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    // Issues a request at a negedge and counts cycles from the accept edge
    // (that cycle counts as 1) until done. poke_at injects a stray start.
    task automatic run_op(input logic [31:0] x, input logic [5:0] amt, input bit hold,
                          input int poke_at, output int lat, output bit busy_seen);
        bus_if.start     = 1'b1;
        bus_if.norm_in   = x;
        bus_if.shift_amt = amt;
        @(posedge clk);
        lat       = 0;
        busy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (lat == poke_at) begin
                bus_if.start     = 1'b1;
                bus_if.norm_in   = ~x;
                bus_if.shift_amt = 6'd0;
            end else if (!hold) begin
                bus_if.start = 1'b0;
            end
            busy_seen |= bus_if.busy;
            if (bus_if.done) break;
        end
        if (!bus_if.done) check("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat;
        bit bsy;
        int dcount;
        logic [31:0] x;
        int n;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{32'h8000_0000, 6'd31, 32'h0000_0001,   1'b0, 1'b0, 11, 1'b1};
        vecs[1] = '{32'hC000_0000, 6'd0,  32'hC000_0000,   1'b0, 1'b0, 1,  1'b0};
        vecs[2] = '{32'hF000_000F, 6'd32, 32'h0000_0000,   1'b0, 1'b1, 5,  1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 6'd40, 32'h0000_0000,   1'b1, 1'b1, 5,  1'b1};
        vecs[4] = '{32'h0000_00FF, 6'd4,  32'h0000_000F,   1'b0, 1'b1, 5,  1'b1};
        vecs[5] = '{32'h1234_5678, 6'd8,  32'h0012_3456,   1'b0, 1'b1, 2,  1'b1};
        vecs[6] = '{32'h0000_0000, 6'd32, 32'h0000_0000,   1'b0, 1'b0, 5,  1'b1};

        bus_if.start     = 1'b0;
        bus_if.norm_in   = '0;
        bus_if.shift_amt = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",   bus_if.busy,     0);
        check("rst_done",   bus_if.done,     0);
        check("rst_data",   bus_if.data_out, 0);
        check("rst_err",    bus_if.err,      0);
        check("rst_sticky", bus_if.sticky,   0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].x, vecs[v].amt, 1'b0, -1, lat, bsy);
            $display("vec %0d: x=%h amt=%0d -> data=%h err=%0d sticky=%0d lat=%0d",
                     v, vecs[v].x, vecs[v].amt, bus_if.data_out, bus_if.err, bus_if.sticky, lat);
            check("vec_data",   bus_if.data_out, vecs[v].d);
            check("vec_err",    bus_if.err,      vecs[v].e);
            check("vec_sticky", bus_if.sticky,   STK & vecs[v].s);
            check("vec_lat",    lat,             vecs[v].lat);
            check("vec_busy",   bsy,             vecs[v].bsy);
            @(negedge clk);
            check("vec_pulse",  bus_if.done,     0);
            check("vec_hold",   bus_if.data_out, vecs[v].d);
        end

        // Stray start during SHIFT is ignored.
        run_op(32'h8000_0000, 6'd31, 1'b0, 2, lat, bsy);
        $display("busy-start: data=%h lat=%0d", bus_if.data_out, lat);
        check("ign_data", bus_if.data_out, 32'h1);
        check("ign_lat",  lat, 11);
        check("ign_err",  bus_if.err, 0);
        @(negedge clk);

        // Start held through done: second request accepted with no gap.
        run_op(32'h0000_0F00, 6'd8, 1'b1, -1, lat, bsy);
        $display("b2b A: data=%h lat=%0d", bus_if.data_out, lat);
        check("b2b_a_data", bus_if.data_out, 32'hF);
        check("b2b_a_lat",  lat, 2);
        run_op(32'h8000_0000, 6'd16, 1'b0, -1, lat, bsy);
        $display("b2b B: data=%h lat=%0d", bus_if.data_out, lat);
        check("b2b_b_data", bus_if.data_out, 32'h0000_8000);
        check("b2b_b_lat",  lat, 3);
        @(negedge clk);

        // Asynchronous reset mid-SHIFT aborts without a done pulse.
        bus_if.start     = 1'b1;
        bus_if.norm_in   = 32'h8000_0000;
        bus_if.shift_amt = 6'd31;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", bus_if.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", bus_if.busy, 0);
        check("abort_data", bus_if.data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_if.done) dcount++;
        end
        $display("reset abort: done pulses after reset=%0d", dcount);
        check("abort_nodone", dcount, 0);

        // Round trip through a clz model.
        for (int t = 0; t < 1000; t++) begin
            x = (t == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
            n = clz32(x);
            run_op((n >= 32) ? 32'h0 : (x << n), 6'(n), 1'b0, -1, lat, bsy);
            $display("rt %0d: x=%h clz=%0d -> data=%h sticky=%0d", t, x, n, bus_if.data_out, bus_if.sticky);
            check("rt_data",   bus_if.data_out, x);
            check("rt_err",    bus_if.err,      0);
            check("rt_sticky", bus_if.sticky,   0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
